// File: rtl/sys_array_sequencer.sv
// Run controller for sys_array_fetcher: weight load, compute kick, ready
// handshake with watchdog, then a row-major scan of the output matrix that
// reduces each row to a signed argmax streamed over valid/ready.
module sys_array_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_A_W  = 1,
  parameter int ARRAY_W_L  = 10,
  parameter int TIMEOUT    = 4096,
  localparam int RW        = (ARRAY_A_W > 1) ? $clog2(ARRAY_A_W) : 1,
  localparam int CW        = (ARRAY_W_L > 1) ? $clog2(ARRAY_W_L) : 1,
  localparam int DW2       = 2 * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  skip_load,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  output logic                  weights_load,
  output logic                  start_comp,
  input  logic                  comp_ready,
  output logic [RW-1:0]         res_row,
  output logic [CW-1:0]         res_col,
  input  logic signed [DW2-1:0] res_data,
  output logic                  cls_valid,
  input  logic                  cls_ready,
  output logic [RW-1:0]         cls_row,
  output logic [CW-1:0]         cls_idx,
  output logic signed [DW2-1:0] cls_max
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(ARRAY_A_W - 1);
  localparam logic [CW-1:0]  COL_LAST = CW'(ARRAY_W_L - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_KICK,
    S_WAIT_LO,
    S_WAIT_HI,
    S_SCAN,
    S_EMIT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [WDW-1:0]        wd_q, wd_d;
  logic [RW-1:0]         res_row_q, res_row_d;
  logic [CW-1:0]         res_col_q, res_col_d;
  logic signed [DW2-1:0] run_max_q, run_max_d;
  logic [CW-1:0]         run_idx_q, run_idx_d;
  logic                  cls_valid_q, cls_valid_d;
  logic [RW-1:0]         cls_row_q, cls_row_d;
  logic [CW-1:0]         cls_idx_q, cls_idx_d;
  logic signed [DW2-1:0] cls_max_q, cls_max_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  weights_load_q, weights_load_d;
  logic                  start_comp_q, start_comp_d;

  logic                  take;
  logic signed [DW2-1:0] scan_max;
  logic [CW-1:0]         scan_idx;

  // Running argmax candidate for the element addressed this cycle
  always_comb begin
    take     = (res_col_q == '0) || (res_data > run_max_q);
    scan_max = take ? res_data : run_max_q;
    scan_idx = take ? res_col_q : run_idx_q;
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d       = state_q;
    wd_d          = wd_q;
    res_row_d     = res_row_q;
    res_col_d     = res_col_q;
    run_max_d     = run_max_q;
    run_idx_d     = run_idx_q;
    cls_valid_d   = cls_valid_q;
    cls_row_d     = cls_row_q;
    cls_idx_d     = cls_idx_q;
    cls_max_d     = cls_max_q;
    timeout_err_d = timeout_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          timeout_err_d = 1'b0;
          state_d       = skip_load ? S_KICK : S_LOAD;
        end
      end
      S_LOAD: state_d = S_KICK;
      S_KICK: begin
        wd_d    = '0;
        state_d = S_WAIT_LO;
      end
      // >= rather than ==: the count can pass TIMEOUT-1 on the LO->HI hop
      S_WAIT_LO: begin
        wd_d = wd_q + 1'b1;
        if (!comp_ready) begin
          state_d = S_WAIT_HI;
        end else if (wd_q >= WD_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = S_DONE;
        end
      end
      S_WAIT_HI: begin
        wd_d = wd_q + 1'b1;
        if (comp_ready) begin
          res_row_d = '0;
          res_col_d = '0;
          state_d   = S_SCAN;
        end else if (wd_q >= WD_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = S_DONE;
        end
      end
      S_SCAN: begin
        run_max_d = scan_max;
        run_idx_d = scan_idx;
        if (res_col_q == COL_LAST) begin
          cls_valid_d = 1'b1;
          cls_row_d   = res_row_q;
          cls_idx_d   = scan_idx;
          cls_max_d   = scan_max;
          state_d     = S_EMIT;
        end else begin
          res_col_d = res_col_q + 1'b1;
        end
      end
      S_EMIT: begin
        if (cls_valid_q && cls_ready) begin
          cls_valid_d = 1'b0;
          if (res_row_q == ROW_LAST) begin
            state_d = S_DONE;
          end else begin
            res_row_d = res_row_q + 1'b1;
            res_col_d = '0;
            state_d   = S_SCAN;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d         = (state_d != S_IDLE);
    done_d         = (state_d == S_DONE);
    weights_load_d = (state_d == S_LOAD);
    start_comp_d   = (state_d == S_KICK);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      wd_q           <= '0;
      res_row_q      <= '0;
      res_col_q      <= '0;
      run_max_q      <= '0;
      run_idx_q      <= '0;
      cls_valid_q    <= 1'b0;
      cls_row_q      <= '0;
      cls_idx_q      <= '0;
      cls_max_q      <= '0;
      timeout_err_q  <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      weights_load_q <= 1'b0;
      start_comp_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      wd_q           <= wd_d;
      res_row_q      <= res_row_d;
      res_col_q      <= res_col_d;
      run_max_q      <= run_max_d;
      run_idx_q      <= run_idx_d;
      cls_valid_q    <= cls_valid_d;
      cls_row_q      <= cls_row_d;
      cls_idx_q      <= cls_idx_d;
      cls_max_q      <= cls_max_d;
      timeout_err_q  <= timeout_err_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      weights_load_q <= weights_load_d;
      start_comp_q   <= start_comp_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout_err  = timeout_err_q;
  assign weights_load = weights_load_q;
  assign start_comp   = start_comp_q;
  assign res_row      = res_row_q;
  assign res_col      = res_col_q;
  assign cls_valid    = cls_valid_q;
  assign cls_row      = cls_row_q;
  assign cls_idx      = cls_idx_q;
  assign cls_max      = cls_max_q;

endmodule

// File: tb/tb_sys_array_sequencer.sv
// Bench for sys_array_sequencer: 2x4 instance with a fetcher model and a
// scoreboard of expected per-row argmax results, plus a 1x1 instance with a
// short watchdog.
module tb_sys_array_sequencer;

  localparam int AW = 2;
  localparam int WL = 4;
  localparam logic signed [15:0] WD_VAL = -16'sd1234;

  typedef struct packed {
    logic [0:0]         row;
    logic [1:0]         idx;
    logic signed [15:0] mx;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, skip_load, comp_ready, cls_ready;
  logic busy, done, timeout_err, weights_load, start_comp, cls_valid;
  logic [0:0] res_row, cls_row;
  logic [1:0] res_col, cls_idx;
  logic signed [15:0] res_data, cls_max;
  logic signed [15:0] mem [AW][WL];

  assign res_data = mem[res_row][res_col];

  logic w_start, w_skip, w_comp_ready, w_cls_ready;
  logic w_busy, w_done, w_timeout_err, w_weights_load, w_start_comp, w_cls_valid;
  logic [0:0] w_res_row, w_res_col, w_cls_row, w_cls_idx;
  logic signed [15:0] w_res_data, w_cls_max;

  assign w_res_data = WD_VAL;

  sys_array_sequencer #(
    .DATA_WIDTH(8), .ARRAY_A_W(AW), .ARRAY_W_L(WL), .TIMEOUT(4096)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start), .skip_load(skip_load),
    .busy(busy), .done(done), .timeout_err(timeout_err),
    .weights_load(weights_load), .start_comp(start_comp),
    .comp_ready(comp_ready), .res_row(res_row), .res_col(res_col),
    .res_data(res_data), .cls_valid(cls_valid), .cls_ready(cls_ready),
    .cls_row(cls_row), .cls_idx(cls_idx), .cls_max(cls_max)
  );

  sys_array_sequencer #(
    .DATA_WIDTH(8), .ARRAY_A_W(1), .ARRAY_W_L(1), .TIMEOUT(16)
  ) u_wd (
    .clk(clk), .reset(reset), .start(w_start), .skip_load(w_skip),
    .busy(w_busy), .done(w_done), .timeout_err(w_timeout_err),
    .weights_load(w_weights_load), .start_comp(w_start_comp),
    .comp_ready(w_comp_ready), .res_row(w_res_row), .res_col(w_res_col),
    .res_data(w_res_data), .cls_valid(w_cls_valid), .cls_ready(w_cls_ready),
    .cls_row(w_cls_row), .cls_idx(w_cls_idx), .cls_max(w_cls_max)
  );

  int   errors = 0;
  int   checks = 0;
  int   done_cnt, wl_cnt, pop_cnt;
  int   fetch_lat = 20;
  int   stim [AW*WL];
  exp_t exp_q [$];

  // Scoreboard consumer and pulse counters, sampled mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (weights_load) wl_cnt++;
      if (cls_valid && cls_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_extra: got row=%0d idx=%0d max=%0d, required no result",
                   cls_row, cls_idx, cls_max);
        end else begin
          e = exp_q.pop_front();
          pop_cnt++;
          if ({cls_row, cls_idx, cls_max} !== {e.row, e.idx, e.mx}) begin
            errors++;
            $display("FAIL scoreboard_cls: got row=%0d idx=%0d max=%0d, required row=%0d idx=%0d max=%0d",
                     cls_row, cls_idx, cls_max, e.row, e.idx, e.mx);
          end
        end
      end
    end
  end

  // Fetcher model: drop ready the cycle after start_comp, raise it fetch_lat cycles later
  initial begin
    comp_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (start_comp && !reset) begin
        @(posedge clk);
        #2 comp_ready = 1'b0;
        repeat (fetch_lat) @(posedge clk);
        #2 comp_ready = 1'b1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  task automatic load_matrix();
    exp_t e;
    int best, bi;
    for (int r = 0; r < AW; r++) begin
      for (int c = 0; c < WL; c++) mem[r][c] = 16'(stim[r*WL + c]);
      best = stim[r*WL];
      bi   = 0;
      for (int c = 1; c < WL; c++) begin
        if (stim[r*WL + c] > best) begin
          best = stim[r*WL + c];
          bi   = c;
        end
      end
      e.row = 1'(r);
      e.idx = 2'(bi);
      e.mx  = 16'(best);
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_counts();
    done_cnt = 0;
    wl_cnt   = 0;
    pop_cnt  = 0;
  endtask

  task automatic pulse_start(input logic skip);
    @(posedge clk);
    #2 start = 1'b1; skip_load = skip;
    @(posedge clk);
    #2 start = 1'b0; skip_load = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s_done_wait: got no done within %0d cycles, required a done pulse", name, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, timeout_err, weights_load, start_comp, cls_valid,
         res_row, res_col, cls_row, cls_idx, cls_max} !== '0) begin
      errors++;
      $display("FAIL reset_dut: got busy=%b done=%b terr=%b wl=%b sc=%b cv=%b row=%0d col=%0d crow=%0d idx=%0d max=%0d, required all 0",
               busy, done, timeout_err, weights_load, start_comp, cls_valid,
               res_row, res_col, cls_row, cls_idx, cls_max);
    end
    checks++;
    if ({w_busy, w_done, w_timeout_err, w_weights_load, w_start_comp, w_cls_valid,
         w_res_row, w_res_col, w_cls_row, w_cls_idx, w_cls_max} !== '0) begin
      errors++;
      $display("FAIL reset_wd: got busy=%b done=%b terr=%b cv=%b max=%0d, required all 0",
               w_busy, w_done, w_timeout_err, w_cls_valid, w_cls_max);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_normal();
    cls_ready = 1'b1;
    fetch_lat = 20;
    stim = '{3, -7, 9, 2, -5, -1, -8, -1};
    load_matrix();
    clear_counts();
    pulse_start(1'b0);
    @(negedge clk);
    checks++;
    if ({weights_load, start_comp, busy} !== 3'b101) begin
      errors++;
      $display("FAIL normal_load_cycle: got wl=%b sc=%b busy=%b, required wl=1 sc=0 busy=1",
               weights_load, start_comp, busy);
    end
    @(negedge clk);
    checks++;
    if ({weights_load, start_comp} !== 2'b01) begin
      errors++;
      $display("FAIL normal_kick_cycle: got wl=%b sc=%b, required wl=0 sc=1", weights_load, start_comp);
    end
    wait_done(200, "normal");
    @(negedge clk);
    checks++;
    if ({done, busy, timeout_err} !== 3'b000) begin
      errors++;
      $display("FAIL normal_after_done: got done=%b busy=%b terr=%b, required 0 0 0", done, busy, timeout_err);
    end
    checks++;
    if (done_cnt !== 1 || pop_cnt !== 2 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL normal_counts: got done=%0d results=%0d pending=%0d, required 1 2 0",
               done_cnt, pop_cnt, exp_q.size());
    end
  endtask

  task automatic test_skip_load();
    cls_ready = 1'b1;
    fetch_lat = 6;
    stim = '{4, 4, 4, 4, -32768, -20000, -32767, -20000};
    load_matrix();
    clear_counts();
    pulse_start(1'b1);
    @(negedge clk);
    checks++;
    if ({weights_load, start_comp} !== 2'b01) begin
      errors++;
      $display("FAIL skip_kick_cycle: got wl=%b sc=%b, required wl=0 sc=1", weights_load, start_comp);
    end
    wait_done(200, "skip");
    @(negedge clk);
    checks++;
    if (wl_cnt !== 0 || done_cnt !== 1 || pop_cnt !== 2 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL skip_counts: got wl=%0d done=%0d results=%0d pending=%0d, required 0 1 2 0",
               wl_cnt, done_cnt, pop_cnt, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    bit seen = 0;
    exp_t e0;
    cls_ready = 1'b0;
    fetch_lat = 4;
    for (int i = 0; i < AW*WL; i++) stim[i] = int'($urandom_range(0, 65535)) - 32768;
    load_matrix();
    e0 = exp_q[0];
    clear_counts();
    pulse_start(1'b1);
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (cls_valid) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL bp_valid_wait: got no cls_valid within 100 cycles, required cls_valid");
    end
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if ({cls_valid, cls_row, cls_idx, cls_max, res_row, res_col} !==
          {1'b1, e0.row, e0.idx, e0.mx, 1'b0, 2'd3}) begin
        errors++;
        $display("FAIL bp_hold_%0d: got cv=%b row=%0d idx=%0d max=%0d rrow=%0d rcol=%0d, required cv=1 row=%0d idx=%0d max=%0d rrow=0 rcol=3",
                 k, cls_valid, cls_row, cls_idx, cls_max, res_row, res_col, e0.row, e0.idx, e0.mx);
      end
    end
    @(posedge clk);
    #2 cls_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({cls_valid, res_row, res_col} !== {1'b0, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL bp_row1_start: got cv=%b rrow=%0d rcol=%0d, required cv=0 rrow=1 rcol=0",
               cls_valid, res_row, res_col);
    end
    @(negedge clk);
    checks++;
    if (res_col !== 2'd1) begin
      errors++;
      $display("FAIL bp_row1_step: got rcol=%0d, required 1", res_col);
    end
    wait_done(100, "bp");
    @(negedge clk);
    checks++;
    if (pop_cnt !== 2 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL bp_counts: got results=%0d pending=%0d, required 2 0", pop_cnt, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_scan();
    bit seen = 0;
    cls_ready = 1'b1;
    fetch_lat = 5;
    stim = '{10, 20, 30, 40, 7, -3, 100, 5};
    load_matrix();
    clear_counts();
    pulse_start(1'b1);
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (pop_cnt == 1 && res_row == 1'b1 && busy && !cls_valid) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL rst_scan_wait: got no row1 scan within 100 cycles, required row1 scan");
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, timeout_err, weights_load, start_comp, cls_valid,
         res_row, res_col, cls_row, cls_idx, cls_max} !== '0) begin
      errors++;
      $display("FAIL rst_scan_outputs: got busy=%b done=%b cv=%b row=%0d col=%0d crow=%0d idx=%0d max=%0d, required all 0",
               busy, done, cls_valid, res_row, res_col, cls_row, cls_idx, cls_max);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_scan_no_done: got done pulses=%0d busy=%b, required 0 0", done_cnt, busy);
    end
    exp_q.delete();
    stim = '{-1, -2, -3, 0, 50, 51, 51, -90};
    load_matrix();
    clear_counts();
    pulse_start(1'b0);
    wait_done(200, "rst_rerun");
    @(negedge clk);
    checks++;
    if (pop_cnt !== 2 || done_cnt !== 1 || wl_cnt !== 1 || exp_q.size() !== 0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_rerun_counts: got results=%0d done=%0d wl=%0d pending=%0d terr=%b, required 2 1 1 0 0",
               pop_cnt, done_cnt, wl_cnt, exp_q.size(), timeout_err);
    end
  endtask

  task automatic test_watchdog();
    w_comp_ready = 1'b1;
    w_cls_ready  = 1'b1;
    @(posedge clk);
    #2 w_start = 1'b1; w_skip = 1'b1;
    @(posedge clk);
    #2 w_start = 1'b0; w_skip = 1'b0;
    @(negedge clk);
    checks++;
    if (w_start_comp !== 1'b1) begin
      errors++;
      $display("FAIL wd_kick: got sc=%b, required 1", w_start_comp);
    end
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      checks++;
      if ({w_done, w_timeout_err, w_busy, w_cls_valid} !==
          {(n == 17), (n >= 17), (n <= 17), 1'b0}) begin
        errors++;
        $display("FAIL wd_cycle_%0d: got done=%b terr=%b busy=%b cv=%b, required done=%b terr=%b busy=%b cv=0",
                 n, w_done, w_timeout_err, w_busy, w_cls_valid, (n == 17), (n >= 17), (n <= 17));
      end
    end
  endtask

  task automatic test_wd_clear();
    bit seen = 0;
    @(posedge clk);
    #2 w_start = 1'b1; w_skip = 1'b0;
    @(posedge clk);
    #2 w_start = 1'b0;
    @(negedge clk);
    checks++;
    if ({w_timeout_err, w_weights_load} !== 2'b01) begin
      errors++;
      $display("FAIL wd_clear_on_start: got terr=%b wl=%b, required terr=0 wl=1", w_timeout_err, w_weights_load);
    end
    for (int i = 0; i < 10 && !seen; i++) begin
      if (w_start_comp) seen = 1;
      else @(negedge clk);
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL wd1_kick_wait: got no start_comp within 10 cycles, required start_comp");
    end
    @(posedge clk);
    #2 w_comp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 w_comp_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (w_cls_valid) seen = 1;
    end
    checks++;
    if (!seen || {w_cls_row, w_cls_idx, w_cls_max} !== {1'b0, 1'b0, WD_VAL}) begin
      errors++;
      $display("FAIL wd1_cls: got seen=%b row=%0d idx=%0d max=%0d, required seen=1 row=0 idx=0 max=%0d",
               seen, w_cls_row, w_cls_idx, w_cls_max, WD_VAL);
    end
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (w_done) seen = 1;
    end
    checks++;
    if (!seen || w_timeout_err !== 1'b0 || w_res_row !== 1'b0 || w_res_col !== 1'b0) begin
      errors++;
      $display("FAIL wd1_done: got seen=%b terr=%b rrow=%0d rcol=%0d, required seen=1 terr=0 rrow=0 rcol=0",
               seen, w_timeout_err, w_res_row, w_res_col);
    end
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    skip_load    = 1'b0;
    cls_ready    = 1'b1;
    w_start      = 1'b0;
    w_skip       = 1'b0;
    w_comp_ready = 1'b1;
    w_cls_ready  = 1'b1;
    clear_counts();
    test_reset();
    test_normal();
    test_skip_load();
    test_backpressure();
    test_reset_mid_scan();
    test_watchdog();
    test_wd_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sys_array_sequencer.md
Name: sys_array_sequencer

Overview:
- Run controller for sys_array_fetcher: issues weight load and compute start, waits on the fetcher's ready with a watchdog, then scans the output matrix element by element.
- Reduces each output row to a signed argmax (class index plus max value) and streams one result per row over a valid/ready handshake.
- Sits between top-level control (buttons/host) and the fetcher; the wrapper muxes out_data by res_row/res_col into res_data.

Parameters:
DATA_WIDTH, 8, fetcher input width; res_data is 2*DATA_WIDTH signed
ARRAY_A_W, 1, output rows (data rows)
ARRAY_W_L, 10, output columns (classes)
TIMEOUT, 4096, max cycles spent in WAIT_LO+WAIT_HI before abort

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  run request, sampled in IDLE only
skip_load  in  1  sampled with start; 1 = omit weights_load phase
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on run end (normal or timeout)
timeout_err  out  1  set on watchdog expiry; cleared on next accepted start
weights_load  out  1  one-cycle pulse to fetcher
start_comp  out  1  one-cycle pulse to fetcher
comp_ready  in  1  fetcher ready
res_row  out  RW=max(1,$clog2(ARRAY_A_W))  result row address
res_col  out  CW=max(1,$clog2(ARRAY_W_L))  result column address
res_data  in  2*DATA_WIDTH  signed out_data[res_row][res_col], combinational from wrapper
cls_valid  out  1  per-row result valid
cls_ready  in  1  consumer accept
cls_row  out  RW  row of current result
cls_idx  out  CW  argmax column
cls_max  out  2*DATA_WIDTH  signed max value

Behaviour:
- All outputs registered. Reset values: all 1-bit outputs 0; res_row, res_col, cls_row, cls_idx, cls_max 0; state IDLE; watchdog 0.
- IDLE: start=1 -> clear timeout_err; go to LOAD, or KICK if skip_load=1. start in any other state is ignored.
- LOAD: weights_load=1 for exactly this cycle -> KICK.
- KICK: start_comp=1 for exactly this cycle; watchdog cleared -> WAIT_LO.
- WAIT_LO: wait for comp_ready=0 (fetcher acknowledged) -> WAIT_HI.
- WAIT_HI: wait for comp_ready=1 -> SCAN with res_row=0, res_col=0.
- Watchdog increments every cycle in WAIT_LO/WAIT_HI. When the count reaches TIMEOUT-1 and the exit condition is not met: timeout_err=1, go to DONE, no cls output. The exit condition wins if both occur in the same cycle.
- SCAN: one element per cycle, row-major; res_data is sampled in the same cycle its address is presented.
  - col 0 loads the running max and idx=0.
  - Later columns replace the running max only if res_data > running max (strict signed compare), so ties keep the lowest column.
  - After col ARRAY_W_L-1: -> EMIT with cls_valid=1, cls_row, cls_idx, cls_max stable. Address does not advance.
- EMIT: hold until cls_valid&&cls_ready.
  - Last row -> DONE.
  - Otherwise res_row+1, res_col=0 -> SCAN. The handshake cycle clears cls_valid.
  - Scan cost: ARRAY_W_L cycles per row, plus at least one EMIT cycle.
- DONE: done=1 for one cycle -> IDLE.
- Fetcher latency is unconstrained apart from the watchdog. A comp_ready glitch while in SCAN/EMIT is ignored.
- Reset in any state: immediate return to IDLE with reset values. Any in-flight cls result is lost; no done pulse.
- ARRAY_A_W=1 or ARRAY_W_L=1 must work; with ARRAY_W_L=1, cls_idx is always 0.

Test Plan:
- Normal run (ARRAY_A_W=2, ARRAY_W_L=4, skip_load=0):
  - Stimulus: fetcher model drops ready 1 cycle after start_comp and raises it after 20 cycles; rows {3,-7,9,2} and {-5,-1,-8,-1}; cls_ready=1.
  - Required: weights_load then start_comp in consecutive cycles; cls (row0, idx2, max9), then (row1, idx1, max-1); one done pulse; timeout_err=0.
- skip_load=1: weights_load never asserts; start_comp asserts in the cycle after start is sampled.
- Watchdog (TIMEOUT=16, comp_ready stuck 1):
  - Required: done pulse and timeout_err=1 exactly 16 cycles after entering WAIT_LO; cls_valid never asserts.
  - A following start clears timeout_err.
- Backpressure: hold cls_ready=0 for 10 cycles on row0. Required: cls_* stable and res_row/res_col frozen; row1 scan starts the cycle after acceptance.
- All-equal row {4,4,4,4} -> idx0, max4. All-negative row {-128*256 … } -> correct signed max.
- Assert reset during SCAN of row1. Required: all outputs 0 immediately, busy=0, no done pulse; a new start runs cleanly.
